odin_obi_mem_port: RTL and testbench

OBI slave endpoint placed behind the tinyODIN address decoder, one instance per tinyODIN memory (spike, neuron, synapse). It accepts granted OBI transactions, drives the core's single-port SRAM through a priority-aware access port with a bit-level write mask, and returns exactly one in-order response per granted transaction after a fixed read latency. It also provides a starvation guard so a core that holds its SRAM cannot block the bus indefinitely.

---
 rtl/odin_obi_mem_port.sv | 164 ++++++++++++++++
 tb/tb_odin_obi_mem_port.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/odin_obi_mem_port.sv
// OBI slave endpoint for one tinyODIN memory (spike, neuron or synapse).
// Grants OBI requests whenever the core leaves the SRAM free. It drives the
// single-port SRAM with a bit-level write mask. It returns one in-order
// response per grant, exactly RD_LAT cycles after that grant. A starvation
// guard asks the core to yield when the bus has been blocked too long.

package odin_obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } rsp_t;

endpackage

module odin_obi_mem_port
  import odin_obi_pkg::*;
#(
  parameter int          ADDR_W     = 13,             // SRAM word-address width, at most 17
  parameter int          RD_LAT     = 1,              // SRAM read latency, 1 or 2
  parameter int          STARVE_MAX = 15,             // blocked cycles before priority request
  parameter logic [31:0] ERR_DATA   = 32'hBADC_AB1E   // rdata for out-of-range reads
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  req_t              obi_req_i,
  output rsp_t              obi_resp_o,
  input  logic              mem_busy_i,
  output logic              obi_pri_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [31:0]       mem_wmask_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic gnt;
  logic oor;
  logic unused_addr_bits;

  // The core owns the SRAM while busy. Granting is purely combinational.
  assign gnt = obi_req_i.req && !mem_busy_i;

  // Word addresses above the SRAM size (up to the region boundary) are out of range.
  if (ADDR_W + 2 <= 19) begin : g_oor
    assign oor = |obi_req_i.addr[19:ADDR_W+2];
  end else begin : g_no_oor
    assign oor = 1'b0;
  end

  // The top address bits are consumed by the upstream decoder. The byte offset
  // is meaningless for word accesses.
  assign unused_addr_bits = ^{obi_req_i.addr[31:20], obi_req_i.addr[1:0]};

  // ---------------------------------------------------------------------------
  // SRAM access port
  // ---------------------------------------------------------------------------
  // Drive the SRAM only for a granted request outside reset. Every field rests at 0 otherwise.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves
    // a signal unassigned and no latch can be inferred.
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    if (gnt && !rst_i) begin
      for (int i = 0; i < 4; i++) begin
        mem_wmask_o[8*i +: 8] = {8{obi_req_i.be[i]}};
      end
      if (!oor) begin
        mem_en_o    = 1'b1;
        mem_we_o    = obi_req_i.we;
        mem_addr_o  = obi_req_i.addr[ADDR_W+1:2];
        mem_wdata_o = obi_req_i.wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipeline: RD_LAT stages of {valid, is_read, oor}
  // ---------------------------------------------------------------------------
  logic [RD_LAT-1:0] valid_q;
  logic [RD_LAT-1:0] is_read_q;
  logic [RD_LAT-1:0] oor_q;

  // Shift the valid bits each cycle. Reset drops every response still in flight.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments, so every stage
    // samples the value its predecessor held before this edge.
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Shift the per-transaction attributes alongside the valid bits.
  always_ff @(posedge clk_i) begin
    // NOTE: the attribute bits are deliberately left out of reset. They are
    // only looked at when the matching valid bit is set, and that bit is reset.
    is_read_q[0] <= !obi_req_i.we;
    oor_q[0]     <= oor;
    for (int i = 1; i < RD_LAT; i++) begin
      is_read_q[i] <= is_read_q[i-1];
      oor_q[i]     <= oor_q[i-1];
    end
  end

  logic        rvalid;
  logic [31:0] rdata;

  assign rvalid = valid_q[RD_LAT-1] && !rst_i;

  // Select read data. Returns SRAM data, the error pattern, or 0 for writes and idle cycles.
  always_comb begin
    rdata = '0;
    if (rvalid && is_read_q[RD_LAT-1]) begin
      rdata = oor_q[RD_LAT-1] ? ERR_DATA : mem_rdata_i;
    end
  end

  assign obi_resp_o = '{gnt: gnt, rvalid: rvalid, rdata: rdata};

  // ---------------------------------------------------------------------------
  // Starvation guard
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] starve_cnt;

  // Count consecutive blocked cycles, saturating. Clear on a grant or when the request goes idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (obi_req_i.req && mem_busy_i) begin
      if (starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  assign obi_pri_o = (starve_cnt == CNT_MAX) && obi_req_i.req && !rst_i;

endmodule

// File: tb/tb_odin_obi_mem_port.sv
// Directed bench for odin_obi_mem_port. One instance uses RD_LAT=1 and one
// uses RD_LAT=2. Each instance has its own small behavioural SRAM.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled on the falling edge.

module tb_odin_obi_mem_port;
  import odin_obi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  req_t        req1, req2;
  rsp_t        rsp1, rsp2;
  logic        busy1, busy2, pri1, pri2;
  logic        en1, en2, we1, we2;
  logic [12:0] addr1, addr2;
  logic [31:0] wd1, wd2, wm1, wm2, rd1, rd2, rd2_s1;
  logic [31:0] mem1 [256];
  logic [31:0] mem2 [256];

  int total = 0;
  int bad   = 0;

  odin_obi_mem_port #(.ADDR_W(13), .RD_LAT(1), .STARVE_MAX(15)) u_lat1 (
    .clk_i(clk), .rst_i(rst), .obi_req_i(req1), .obi_resp_o(rsp1),
    .mem_busy_i(busy1), .obi_pri_o(pri1), .mem_en_o(en1), .mem_we_o(we1),
    .mem_addr_o(addr1), .mem_wdata_o(wd1), .mem_wmask_o(wm1), .mem_rdata_i(rd1)
  );

  odin_obi_mem_port #(.ADDR_W(13), .RD_LAT(2), .STARVE_MAX(15)) u_lat2 (
    .clk_i(clk), .rst_i(rst), .obi_req_i(req2), .obi_resp_o(rsp2),
    .mem_busy_i(busy2), .obi_pri_o(pri2), .mem_en_o(en2), .mem_we_o(we2),
    .mem_addr_o(addr2), .mem_wdata_o(wd2), .mem_wmask_o(wm2), .mem_rdata_i(rd2)
  );

  // Behavioural SRAMs. Writes are bit-masked. Reads return data after 1 or 2 cycles.
  always @(posedge clk) begin
    if (en1) begin
      if (we1) mem1[addr1[7:0]] <= (mem1[addr1[7:0]] & ~wm1) | (wd1 & wm1);
      else     rd1 <= mem1[addr1[7:0]];
    end
    if (en2) begin
      if (we2) mem2[addr2[7:0]] <= (mem2[addr2[7:0]] & ~wm2) | (wd2 & wm2);
      else     rd2_s1 <= mem2[addr2[7:0]];
    end
    rd2 <= rd2_s1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set1(input logic r, input logic w, input logic [3:0] be,
                      input logic [31:0] a, input logic [31:0] d);
    req1.req = r; req1.we = w; req1.be = be; req1.addr = a; req1.wdata = d;
  endtask

  task automatic set2(input logic r, input logic w, input logic [3:0] be,
                      input logic [31:0] a, input logic [31:0] d);
    req2.req = r; req2.we = w; req2.be = be; req2.addr = a; req2.wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; busy1 = 1'b0; busy2 = 1'b0;
    set1(0, 0, 4'h0, 0, 0); set2(0, 0, 4'h0, 0, 0);
    next();
    set1(1, 0, 4'hF, 32'h40, 0);
    @(negedge clk);
    total++; if (rsp1.gnt !== 1'b1)    begin bad++; $display("FAIL reset_gnt: got %b want 1", rsp1.gnt); end
    total++; if (en1 !== 1'b0)         begin bad++; $display("FAIL reset_mem_en: got %b want 0", en1); end
    total++; if (rsp1.rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b want 0", rsp1.rvalid); end
    total++; if (pri1 !== 1'b0)        begin bad++; $display("FAIL reset_pri: got %b want 0", pri1); end
    next();
    rst = 1'b0; set1(0, 0, 4'h0, 0, 0);
    @(negedge clk);
    total++; if (rsp1.rvalid !== 1'b0) begin bad++; $display("FAIL reset_no_resp: got %b want 0", rsp1.rvalid); end
    total++; if (rsp2.rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid2: got %b want 0", rsp2.rvalid); end
  endtask

  task automatic test_single_read();
    next();
    set1(1, 1, 4'hF, 32'h40, 32'h1234_5678);
    @(negedge clk);
    total++; if (rsp1.gnt !== 1'b1)         begin bad++; $display("FAIL wr_gnt: got %b want 1", rsp1.gnt); end
    total++; if (en1 !== 1'b1 || we1 !== 1'b1) begin bad++; $display("FAIL wr_en_we: got %b%b want 11", en1, we1); end
    total++; if (addr1 !== 13'h10)          begin bad++; $display("FAIL wr_addr: got %h want 0010", addr1); end
    total++; if (wd1 !== 32'h1234_5678)     begin bad++; $display("FAIL wr_wdata: got %h want 12345678", wd1); end
    total++; if (wm1 !== 32'hFFFF_FFFF)     begin bad++; $display("FAIL wr_mask: got %h want ffffffff", wm1); end
    next();
    set1(1, 0, 4'hF, 32'h40, 0);
    @(negedge clk);
    total++; if (rsp1.gnt !== 1'b1 || en1 !== 1'b1 || we1 !== 1'b0) begin bad++; $display("FAIL rd_strobe: got gnt=%b en=%b we=%b want 1 1 0", rsp1.gnt, en1, we1); end
    total++; if (addr1 !== 13'h10)          begin bad++; $display("FAIL rd_addr: got %h want 0010", addr1); end
    total++; if (rsp1.rvalid !== 1'b1 || rsp1.rdata !== 32'h0) begin bad++; $display("FAIL wr_resp: got v=%b d=%h want v=1 d=0", rsp1.rvalid, rsp1.rdata); end
    next();
    set1(0, 0, 4'h0, 0, 0);
    @(negedge clk);
    total++; if (rsp1.rvalid !== 1'b1 || rsp1.rdata !== 32'h1234_5678) begin bad++; $display("FAIL rd_resp: got v=%b d=%h want v=1 d=12345678", rsp1.rvalid, rsp1.rdata); end
    total++; if (en1 !== 1'b0 || addr1 !== 13'h0) begin bad++; $display("FAIL idle_port: got en=%b addr=%h want 0 0", en1, addr1); end
    next();
    @(negedge clk);
    total++; if (rsp1.rvalid !== 1'b0 || rsp1.rdata !== 32'h0) begin bad++; $display("FAIL rd_idle: got v=%b d=%h want v=0 d=0", rsp1.rvalid, rsp1.rdata); end
  endtask

  task automatic test_byte_mask();
    next();
    set1(1, 1, 4'hF, 32'h44, 32'h1122_3344);
    next();
    set1(1, 1, 4'b0101, 32'h44, 32'hAABB_CCDD);
    @(negedge clk);
    total++; if (wm1 !== 32'h00FF_00FF) begin bad++; $display("FAIL bm_mask: got %h want 00ff00ff", wm1); end
    next();
    set1(1, 0, 4'hF, 32'h44, 0);
    next();
    set1(0, 0, 4'h0, 0, 0);
    @(negedge clk);
    total++; if (rsp1.rvalid !== 1'b1 || rsp1.rdata !== 32'h11BB_33DD) begin bad++; $display("FAIL bm_merge: got v=%b d=%h want v=1 d=11bb33dd", rsp1.rvalid, rsp1.rdata); end
  endtask

  task automatic test_back_to_back();
    logic        exp_v;
    logic [31:0] exp_d;
    for (int k = 0; k < 10; k++) begin
      next();
      if (k < 8) set2(1, 1, 4'hF, 32'h100 + 32'(4 * k), 32'hC0DE_0000 + 32'(k));
      else       set2(0, 0, 4'h0, 0, 0);
      @(negedge clk);
      exp_v = (k >= 2);
      total++; if (rsp2.rvalid !== exp_v || rsp2.rdata !== 32'h0) begin bad++; $display("FAIL b2b_wr_resp[%0d]: got v=%b d=%h want v=%b d=0", k, rsp2.rvalid, rsp2.rdata, exp_v); end
    end
    for (int k = 0; k < 11; k++) begin
      next();
      if (k < 8) set2(1, 0, 4'hF, 32'h100 + 32'(4 * k), 0);
      else       set2(0, 0, 4'h0, 0, 0);
      @(negedge clk);
      exp_v = (k >= 2) && (k < 10);
      exp_d = exp_v ? 32'hC0DE_0000 + 32'(k - 2) : 32'h0;
      total++; if (rsp2.gnt !== (k < 8)) begin bad++; $display("FAIL b2b_gnt[%0d]: got %b want %b", k, rsp2.gnt, (k < 8)); end
      total++; if (rsp2.rvalid !== exp_v || rsp2.rdata !== exp_d) begin bad++; $display("FAIL b2b_rd_resp[%0d]: got v=%b d=%h want v=%b d=%h", k, rsp2.rvalid, rsp2.rdata, exp_v, exp_d); end
    end
  endtask

  task automatic test_out_of_range();
    next();
    set1(1, 0, 4'hF, 32'h0008_0000, 0);
    @(negedge clk);
    total++; if (rsp1.gnt !== 1'b1 || en1 !== 1'b0) begin bad++; $display("FAIL oor_rd_port: got gnt=%b en=%b want 1 0", rsp1.gnt, en1); end
    next();
    set1(1, 1, 4'hF, 32'h0008_0040, 32'hFFFF_FFFF);
    @(negedge clk);
    total++; if (rsp1.rvalid !== 1'b1 || rsp1.rdata !== 32'hBADC_AB1E) begin bad++; $display("FAIL oor_rd_resp: got v=%b d=%h want v=1 d=badcab1e", rsp1.rvalid, rsp1.rdata); end
    total++; if (rsp1.gnt !== 1'b1 || en1 !== 1'b0) begin bad++; $display("FAIL oor_wr_port: got gnt=%b en=%b want 1 0", rsp1.gnt, en1); end
    next();
    set1(0, 0, 4'h0, 0, 0);
    @(negedge clk);
    total++; if (rsp1.rvalid !== 1'b1 || rsp1.rdata !== 32'h0) begin bad++; $display("FAIL oor_wr_resp: got v=%b d=%h want v=1 d=0", rsp1.rvalid, rsp1.rdata); end
  endtask

  task automatic test_starvation();
    for (int c = 0; c < 20; c++) begin
      next();
      set1(1, 0, 4'hF, 32'h40, 0); busy1 = 1'b1;
      @(negedge clk);
      total++; if (rsp1.gnt !== 1'b0 || en1 !== 1'b0) begin bad++; $display("FAIL starve_blocked[%0d]: got gnt=%b en=%b want 0 0", c, rsp1.gnt, en1); end
      total++; if (pri1 !== (c >= 15)) begin bad++; $display("FAIL starve_pri[%0d]: got %b want %b", c, pri1, (c >= 15)); end
    end
    next();
    busy1 = 1'b0;
    @(negedge clk);
    total++; if (rsp1.gnt !== 1'b1 || en1 !== 1'b1) begin bad++; $display("FAIL starve_grant: got gnt=%b en=%b want 1 1", rsp1.gnt, en1); end
    next();
    busy1 = 1'b1;
    @(negedge clk);
    total++; if (pri1 !== 1'b0 || rsp1.gnt !== 1'b0) begin bad++; $display("FAIL starve_pri_clear: got pri=%b gnt=%b want 0 0", pri1, rsp1.gnt); end
    total++; if (rsp1.rvalid !== 1'b1 || rsp1.rdata !== 32'h1234_5678) begin bad++; $display("FAIL starve_resp: got v=%b d=%h want v=1 d=12345678", rsp1.rvalid, rsp1.rdata); end
    next();
    set1(0, 0, 4'h0, 0, 0); busy1 = 1'b0;
    @(negedge clk);
    total++; if (rsp1.rvalid !== 1'b0 || pri1 !== 1'b0) begin bad++; $display("FAIL starve_idle: got v=%b pri=%b want 0 0", rsp1.rvalid, pri1); end
  endtask

  task automatic test_reset_midflight();
    for (int c = 0; c < 16; c++) begin
      next();
      set1(1, 0, 4'hF, 32'h40, 0); busy1 = 1'b1;
      if (c == 15) set2(1, 0, 4'hF, 32'h100, 0);
      else         set2(0, 0, 4'h0, 0, 0);
      @(negedge clk);
      total++; if (pri1 !== (c >= 15)) begin bad++; $display("FAIL mf_pri_pre[%0d]: got %b want %b", c, pri1, (c >= 15)); end
    end
    total++; if (rsp2.gnt !== 1'b1) begin bad++; $display("FAIL mf_gnt: got %b want 1", rsp2.gnt); end
    next();
    rst = 1'b1; set2(0, 0, 4'h0, 0, 0);
    @(negedge clk);
    total++; if (pri1 !== 1'b0 || rsp2.rvalid !== 1'b0) begin bad++; $display("FAIL mf_in_reset: got pri=%b v=%b want 0 0", pri1, rsp2.rvalid); end
    for (int p = 0; p < 16; p++) begin
      next();
      rst = 1'b0;
      @(negedge clk);
      total++; if (rsp2.rvalid !== 1'b0 || rsp1.rvalid !== 1'b0) begin bad++; $display("FAIL mf_no_resp[%0d]: got v2=%b v1=%b want 0 0", p, rsp2.rvalid, rsp1.rvalid); end
      total++; if (pri1 !== (p >= 15)) begin bad++; $display("FAIL mf_pri_post[%0d]: got %b want %b", p, pri1, (p >= 15)); end
    end
    next();
    set1(0, 0, 4'h0, 0, 0); busy1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_byte_mask();
    test_back_to_back();
    test_out_of_range();
    test_starvation();
    test_reset_midflight();
    next();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
